lb_rxbuf_reader: RTL

- Reader/consumer side of the local-bus receive buffer that sa_rx fills (lb_rxbuf_wren/wraddr/wrdata, got_frame).
- On each got_frame it fetches the stored frame from the rx buffer RAM read port and parses its 16-bit length header.
- It streams the payload to the application over a valid/ready byte interface with SOF/EOF markers, and counts dropped frames.
- Sits in the control-station bus subsystem beside sa_rx, in the sys_clk domain.

---
 rtl/lb_bus_pkg.sv | 25 ++
 rtl/lb_skid_fifo2.sv | 57 +++++
 rtl/lb_rxbuf_reader.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/lb_bus_pkg.sv
// Shared definitions for the local-bus receive path: reader FSM states,
// rx buffer header layout and the default payload length limit.
package lb_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_HDR,
        LEN,
        PAYLOAD,
        DRAIN,
        DONE
    } rx_state_t;

    localparam logic [15:0] LEN_HI_OFS  = 16'd0;
    localparam logic [15:0] LEN_LO_OFS  = 16'd1;
    localparam logic [15:0] PAYLOAD_OFS = 16'd2;

    localparam int LB_MAX_LEN = 2040;

    // rx buffer addresses wrap modulo 2^16
    function automatic logic [15:0] rxbuf_addr(input logic [15:0] base, input logic [15:0] ofs);
        return base + ofs;
    endfunction

endpackage

// File: rtl/lb_skid_fifo2.sv
// Two-entry first-word-fall-through buffer between the rx buffer read data
// and the application port; an arriving byte bypasses storage when it can.
module lb_skid_fifo2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [1:0] count
);

    logic [7:0] mem_q [2];
    logic [7:0] mem_d [2];
    logic       head_q, head_d;
    logic [1:0] count_q, count_d;
    logic       store;
    logic       pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: 8'h00};
            head_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        out_valid = (count_q != 2'd0) || in_valid;
        out_data  = (count_q != 2'd0) ? mem_q[head_q] : in_data;
        pop       = (count_q != 2'd0) && out_ready;
        // Only store when the byte cannot go straight through an empty buffer
        store     = in_valid && !((count_q == 2'd0) && out_ready);
        mem_d     = mem_q;
        head_d    = head_q;
        count_d   = count_q;
        if (store) begin
            mem_d[head_q ^ count_q[0]] = in_data;
        end
        if (pop) begin
            head_d = ~head_q;
        end
        case ({store, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    assign count = count_q;

endmodule

// File: rtl/lb_rxbuf_reader.sv
// Consumer side of the local-bus rx buffer: reads the length header of each
// stored frame and streams its payload out over a valid/ready byte port.
module lb_rxbuf_reader
    import lb_bus_pkg::*;
#(
    parameter int          MAX_LEN   = LB_MAX_LEN,
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          CNT_W     = 8
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             got_frame,
    input  logic [7:0]       frame_id,
    input  logic [7:0]       frame_type,
    input  logic             sn_error,
    output logic             rxbuf_rden,
    output logic [15:0]      rxbuf_rdaddr,
    input  logic [7:0]       rxbuf_rdata,
    output logic             app_valid,
    input  logic             app_ready,
    output logic [7:0]       app_data,
    output logic             app_sof,
    output logic             app_eof,
    output logic [7:0]       app_id,
    output logic [7:0]       app_type,
    output logic [15:0]      app_len,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] ovr_cnt
);

    rx_state_t        state_q, state_d;
    logic             hdr_step_q, hdr_step_d;
    logic [7:0]       hi_q, hi_d;
    logic [15:0]      len_q, len_d;
    logic [15:0]      rem_q, rem_d;
    logic [15:0]      addr_q, addr_d;
    logic [15:0]      out_idx_q, out_idx_d;
    logic             pl_inflight_q, pl_inflight_d;
    logic [7:0]       id_q, id_d;
    logic [7:0]       type_q, type_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] ovr_q, ovr_d;
    logic             sn_done_q, sn_done_d;

    logic [15:0]      n_len;
    logic             len_big;
    logic             credit_ok;
    logic             eof_hs;
    logic             fifo_valid;
    logic [7:0]       fifo_data;
    logic [1:0]       fifo_count;

    lb_skid_fifo2 u_fifo (
        .clk       (sys_clk),
        .rst       (rst),
        .in_valid  (pl_inflight_q),
        .in_data   (rxbuf_rdata),
        .out_valid (fifo_valid),
        .out_ready (app_ready),
        .out_data  (fifo_data),
        .count     (fifo_count)
    );

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q       <= IDLE;
            hdr_step_q    <= 1'b0;
            hi_q          <= 8'h00;
            len_q         <= 16'h0000;
            rem_q         <= 16'h0000;
            addr_q        <= 16'h0000;
            out_idx_q     <= 16'h0000;
            pl_inflight_q <= 1'b0;
            id_q          <= 8'h00;
            type_q        <= 8'h00;
            drop_q        <= '0;
            ovr_q         <= '0;
            sn_done_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hdr_step_q    <= hdr_step_d;
            hi_q          <= hi_d;
            len_q         <= len_d;
            rem_q         <= rem_d;
            addr_q        <= addr_d;
            out_idx_q     <= out_idx_d;
            pl_inflight_q <= pl_inflight_d;
            id_q          <= id_d;
            type_q        <= type_d;
            drop_q        <= drop_d;
            ovr_q         <= ovr_d;
            sn_done_q     <= sn_done_d;
        end
    end

    // The low length byte is only on rxbuf_rdata during LEN, so N is decoded live
    assign n_len     = {hi_q, rxbuf_rdata};
    assign len_big   = n_len > 16'(MAX_LEN);
    assign credit_ok = ({1'b0, pl_inflight_q} + fifo_count) < 2'd2;
    assign eof_hs    = app_valid && app_ready && app_eof;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (got_frame && !sn_error) state_d = RD_HDR;
            RD_HDR:  if (hdr_step_q) state_d = LEN;
            LEN:     state_d = ((n_len == 16'd0) || len_big) ? DONE : PAYLOAD;
            PAYLOAD: begin
                if (eof_hs) begin
                    state_d = DONE;
                end else if (rem_q == 16'd0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN:   if (eof_hs) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hdr_step_d    = hdr_step_q;
        hi_d          = hi_q;
        len_d         = len_q;
        rem_d         = rem_q;
        addr_d        = addr_q;
        out_idx_d     = out_idx_q;
        id_d          = id_q;
        type_d        = type_q;
        drop_d        = drop_q;
        ovr_d         = ovr_q;
        sn_done_d     = 1'b0;
        pl_inflight_d = 1'b0;
        rxbuf_rden    = 1'b0;
        rxbuf_rdaddr  = 16'h0000;
        case (state_q)
            IDLE: begin
                if (got_frame) begin
                    if (sn_error) begin
                        drop_d    = (&drop_q) ? drop_q : drop_q + CNT_W'(1);
                        sn_done_d = 1'b1;
                    end else begin
                        id_d       = frame_id;
                        type_d     = frame_type;
                        hdr_step_d = 1'b0;
                        out_idx_d  = 16'h0000;
                    end
                end
            end
            RD_HDR: begin
                rxbuf_rden   = 1'b1;
                rxbuf_rdaddr = rxbuf_addr(BASE_ADDR, hdr_step_q ? LEN_LO_OFS : LEN_HI_OFS);
                hdr_step_d   = 1'b1;
                if (hdr_step_q) begin
                    hi_d = rxbuf_rdata;
                end
            end
            LEN: begin
                len_d = n_len;
                if (len_big) begin
                    drop_d = (&drop_q) ? drop_q : drop_q + CNT_W'(1);
                end else if (n_len != 16'd0) begin
                    // Buffer is empty here, so the first payload read needs no credit check
                    rxbuf_rden    = 1'b1;
                    rxbuf_rdaddr  = rxbuf_addr(BASE_ADDR, PAYLOAD_OFS);
                    addr_d        = rxbuf_addr(BASE_ADDR, PAYLOAD_OFS + 16'd1);
                    rem_d         = n_len - 16'd1;
                    pl_inflight_d = 1'b1;
                end
            end
            PAYLOAD: begin
                if ((rem_q != 16'd0) && credit_ok) begin
                    rxbuf_rden    = 1'b1;
                    rxbuf_rdaddr  = addr_q;
                    addr_d        = addr_q + 16'd1;
                    rem_d         = rem_q - 16'd1;
                    pl_inflight_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (app_valid && app_ready) begin
            out_idx_d = out_idx_q + 16'd1;
        end
        if (got_frame && (state_q != IDLE)) begin
            ovr_d = (&ovr_q) ? ovr_q : ovr_q + CNT_W'(1);
        end
    end

    always_comb begin
        app_valid  = fifo_valid;
        app_data   = fifo_valid ? fifo_data : 8'h00;
        app_sof    = fifo_valid && (out_idx_q == 16'd0);
        app_eof    = fifo_valid && (out_idx_q == (len_q - 16'd1));
        app_id     = id_q;
        app_type   = type_q;
        app_len    = len_q;
        busy       = (state_q != IDLE);
        frame_done = (state_q == DONE) || sn_done_q;
        drop_cnt   = drop_q;
        ovr_cnt    = ovr_q;
    end

endmodule
